// File: rtl/dropout_pkg.sv
// Shared constants, lane/mask/beat types and the saturating shift helper for the
// dropout gradient gate.
package dropout_pkg;

   localparam int LANES       = 8;
   localparam int DATA_W      = 8;
   localparam int DEPTH       = 16;
   localparam int SCALE_SHIFT = 1;

   typedef logic signed [DATA_W-1:0] lane_t;
   typedef logic [LANES-1:0]         mask_t;
   typedef lane_t [LANES-1:0]        beat_t;

   // Sign-extend to double width, shift, then clamp if the upper bits no longer
   // agree with the result's sign bit. Valid for shift < DATA_W.
   function automatic lane_t sat_shl(input lane_t x, input int unsigned shift);
      logic [2*DATA_W-1:0] wide;
      lane_t               res;
      wide = {{DATA_W{x[DATA_W-1]}}, x} << shift;
      if ((wide[2*DATA_W-1:DATA_W-1] == {(DATA_W+1){1'b0}}) ||
          (wide[2*DATA_W-1:DATA_W-1] == {(DATA_W+1){1'b1}})) begin
         res = lane_t'(wide[DATA_W-1:0]);
      end else if (wide[2*DATA_W-1]) begin
         res = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         res = {1'b0, {(DATA_W-1){1'b1}}};
      end
      return res;
   endfunction

endpackage

// File: rtl/dropout_mask_stack.sv
// LIFO of keep masks: push writes above the top, pop exposes the current top,
// and a simultaneous push+pop overwrites the slot being freed.
module dropout_mask_stack
   import dropout_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   push,
   input  logic                   pop,
   input  mask_t                  push_data,
   output mask_t                  top,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);

   localparam int AW = $clog2(DEPTH);

   mask_t           mem_q [DEPTH];
   logic [AW:0]     count_q, count_d;
   logic [AW-1:0]   top_ptr_s, wr_ptr_s;

   assign empty     = (count_q == {(AW+1){1'b0}});
   assign full      = (count_q == (AW+1)'(DEPTH));
   assign top_ptr_s = count_q[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
   assign top       = empty ? {LANES{1'b0}} : mem_q[top_ptr_s];
   assign count     = count_q;

   always_comb begin
      wr_ptr_s = count_q[AW-1:0];
      count_d  = count_q;
      if (clear) begin
         count_d = {(AW+1){1'b0}};
      end else begin
         case ({push, pop})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = empty ? count_q : count_q - {{AW{1'b0}}, 1'b1};
            2'b11: begin
               // A pop on an empty stack frees nothing, so the push lands at slot 0.
               if (empty) begin
                  count_d = {{AW{1'b0}}, 1'b1};
               end else begin
                  wr_ptr_s = top_ptr_s;
               end
            end
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem_q[wr_ptr_s] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= {(AW+1){1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/dropout_grad_gate.sv
// Backward dropout gate: pops keep masks in reverse order and zeroes dropped lanes of
// each gradient beat. Define DROPOUT_GRAD_SCALE_EN to also saturate-shift kept lanes.
module dropout_grad_gate
   import dropout_pkg::*;
#(
   parameter int LANES       = dropout_pkg::LANES,
   parameter int DATA_W      = dropout_pkg::DATA_W,
   parameter int DEPTH       = dropout_pkg::DEPTH,
   parameter int SCALE_SHIFT = dropout_pkg::SCALE_SHIFT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      mask_valid,
   output logic                      mask_ready,
   input  logic [LANES-1:0]          mask_data,
   input  logic                      grad_valid,
   output logic                      grad_ready,
   input  logic [LANES*DATA_W-1:0]   grad_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DATA_W-1:0]   out_data,
   output logic [LANES-1:0]          out_mask,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      underflow
);

`ifdef DROPOUT_GRAD_SCALE_EN
   localparam int unsigned EFF_SHIFT = SCALE_SHIFT;
`else
   localparam int unsigned EFF_SHIFT = 0;
`endif

   logic                    push_s, pop_s, empty_s, full_s;
   mask_t                   top_s;
   logic [LANES*DATA_W-1:0] gated_s;

   logic                    out_valid_q, out_valid_d;
   logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
   logic [LANES-1:0]        out_mask_q, out_mask_d;
   logic                    underflow_q, underflow_d;

   assign mask_ready = !full_s && !clear;
   assign grad_ready = (!out_valid_q || out_ready) && !clear;
   assign push_s     = mask_valid && mask_ready;
   assign pop_s      = grad_valid && grad_ready;

   dropout_mask_stack #(.DEPTH(DEPTH)) u_stack (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .push      (push_s),
      .pop       (pop_s),
      .push_data (mask_data),
      .top       (top_s),
      .count     (count),
      .empty     (empty_s),
      .full      (full_s)
   );

   // An empty stack reads back as an all-zero mask, so underflow beats come out as zeros.
   always_comb begin
      gated_s = {(LANES*DATA_W){1'b0}};
      for (int i = 0; i < LANES; i++) begin
         if (top_s[i]) begin
            gated_s[i*DATA_W +: DATA_W] = sat_shl(lane_t'(grad_data[i*DATA_W +: DATA_W]), EFF_SHIFT);
         end else begin
            gated_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_mask_d  = out_mask_q;
      underflow_d = underflow_q;
      if (pop_s) begin
         out_valid_d = 1'b1;
         out_data_d  = gated_s;
         out_mask_d  = top_s;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
      if (clear) begin
         underflow_d = 1'b0;
      end else if (pop_s && empty_s) begin
         underflow_d = 1'b1;
      end else begin
         underflow_d = underflow_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= {(LANES*DATA_W){1'b0}};
         out_mask_q  <= {LANES{1'b0}};
         underflow_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_mask_q  <= out_mask_d;
         underflow_q <= underflow_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_mask  = out_mask_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_dropout_grad_gate.sv
// Self-checking bench for dropout_grad_gate: directed scenarios plus random traffic,
// compared against a queue-based reference model of the mask stack and gating rule.
module tb_dropout_grad_gate;

   localparam int LANES = 8;
   localparam int W     = 8;
   localparam int DEPTH = 16;
   localparam int SH    = 1;

   logic        clk = 1'b0;
   logic        rst, clear, mask_valid, grad_valid, out_ready;
   logic        mask_ready, grad_ready, out_valid, underflow;
   logic [7:0]  mask_data, out_mask;
   logic [63:0] grad_data, out_data;
   logic [4:0]  count;

   int checks = 0;
   int failures = 0;

   logic [7:0]  mq[$];
   logic        exp_valid;
   logic [63:0] exp_data;
   logic [7:0]  exp_mask;
   logic        exp_uf;

   dropout_grad_gate dut (
      .clk(clk), .rst(rst), .clear(clear),
      .mask_valid(mask_valid), .mask_ready(mask_ready), .mask_data(mask_data),
      .grad_valid(grad_valid), .grad_ready(grad_ready), .grad_data(grad_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_mask(out_mask), .count(count), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] gate_model(input logic [63:0] g, input logic [7:0] m);
      logic [63:0] r;
      int v;
      r = 64'd0;
      for (int i = 0; i < LANES; i++) begin
         if (m[i]) begin
            v = int'($signed(g[i*W +: W]));
`ifdef DROPOUT_GRAD_SCALE_EN
            v = v * (2 ** SH);
            if (v > 127) v = 127;
            if (v < -128) v = -128;
`endif
            r[i*W +: W] = v[7:0];
         end
      end
      return r;
   endfunction

   function automatic logic [63:0] splat(input int v);
      logic [7:0] b;
      b = v[7:0];
      return {8{b}};
   endfunction

   task automatic model_reset();
      mq.delete();
      exp_valid = 1'b0;
      exp_data  = 64'd0;
      exp_mask  = 8'd0;
      exp_uf    = 1'b0;
   endtask

   // One clock: drive, check readys, advance model, then check registered state.
   task automatic cyc(input logic mv, input logic [7:0] md, input logic gv,
                      input logic [63:0] gd, input logic ordy, input logic clr);
      logic em_r, eg_r;
      logic [7:0] m;
      mask_valid = mv; mask_data = md; grad_valid = gv; grad_data = gd;
      out_ready = ordy; clear = clr;
      #1;
      em_r = (mq.size() < DEPTH) && !clr;
      eg_r = (!exp_valid || ordy) && !clr;
      chk("mask_ready", {63'd0, mask_ready}, {63'd0, em_r});
      chk("grad_ready", {63'd0, grad_ready}, {63'd0, eg_r});
      if (clr) begin
         mq.delete();
         exp_uf = 1'b0;
         if (ordy) exp_valid = 1'b0;
      end else begin
         if (gv && eg_r) begin
            if (mq.size() > 0) begin
               m = mq.pop_back();
            end else begin
               m = 8'd0;
               exp_uf = 1'b1;
            end
            exp_data  = gate_model(gd, m);
            exp_mask  = m;
            exp_valid = 1'b1;
         end else if (ordy) begin
            exp_valid = 1'b0;
         end
         if (mv && em_r) mq.push_back(md);
      end
      @(posedge clk);
      #1;
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
      chk("out_data", out_data, exp_data);
      chk("out_mask", {56'd0, out_mask}, {56'd0, exp_mask});
      chk("count", {59'd0, count}, 64'(mq.size()));
      chk("underflow", {63'd0, underflow}, {63'd0, exp_uf});
   endtask

   task automatic idle();
      cyc(1'b0, 8'd0, 1'b0, 64'd0, 1'b1, 1'b0);
   endtask

   logic [63:0] t1a, t1b, t2p, t2e;

   initial begin
`ifdef DROPOUT_GRAD_SCALE_EN
      t1a = 64'h0000_0000_1414_1414;
      t1b = 64'h1414_1414_0000_0000;
      t2e = 64'h807F_0A80_7F0A_807F;
`else
      t1a = 64'h0000_0000_0A0A_0A0A;
      t1b = 64'h0A0A_0A0A_0000_0000;
      t2e = 64'h9C64_059C_6405_9C64;
`endif
      t2p = 64'h9C64_059C_6405_9C64;

      rst = 1'b1; clear = 1'b0; mask_valid = 1'b0; grad_valid = 1'b0;
      out_ready = 1'b1; mask_data = 8'd0; grad_data = 64'd0;
      model_reset();
      #2;
      chk("rst_count", {59'd0, count}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_mask", {56'd0, out_mask}, 64'd0);
      chk("rst_underflow", {63'd0, underflow}, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // LIFO order and gating
      cyc(1'b1, 8'hF0, 1'b0, 64'd0, 1'b1, 1'b0);
      cyc(1'b1, 8'h0F, 1'b0, 64'd0, 1'b1, 1'b0);
      cyc(1'b0, 8'd0, 1'b1, splat(10), 1'b1, 1'b0);
      chk("t1_beat1", out_data, t1a);
      cyc(1'b0, 8'd0, 1'b1, splat(10), 1'b1, 1'b0);
      chk("t1_beat2", out_data, t1b);
      idle();

      // Saturation corners
      cyc(1'b1, 8'hFF, 1'b0, 64'd0, 1'b1, 1'b0);
      cyc(1'b0, 8'd0, 1'b1, t2p, 1'b1, 1'b0);
      chk("t2_sat", out_data, t2e);
      idle();

      // Fill to full, then pop one, then push+pop at count 5
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'($urandom), 1'b0, 64'd0, 1'b1, 1'b0);
      chk("t3_full_count", {59'd0, count}, 64'd16);
      cyc(1'b1, 8'hAA, 1'b0, 64'd0, 1'b1, 1'b0);
      cyc(1'b0, 8'd0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
      cyc(1'b1, 8'h55, 1'b0, 64'd0, 1'b1, 1'b0);
      while (mq.size() > 5) cyc(1'b0, 8'd0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
      cyc(1'b1, 8'h3C, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
      chk("t3_pushpop_count", {59'd0, count}, 64'd5);
      idle();

      // Underflow, sticky flag, clear
      cyc(1'b0, 8'd0, 1'b0, 64'd0, 1'b1, 1'b1);
      cyc(1'b0, 8'd0, 1'b1, splat(50), 1'b1, 1'b0);
      chk("t4_uf_data", out_data, 64'd0);
      idle(); idle();
      chk("t4_uf_sticky", {63'd0, underflow}, 64'd1);
      cyc(1'b0, 8'd0, 1'b0, 64'd0, 1'b1, 1'b1);
      cyc(1'b1, 8'h81, 1'b1, splat(7), 1'b1, 1'b0);
      cyc(1'b0, 8'd0, 1'b0, 64'd0, 1'b1, 1'b1);

      // Back-pressure
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom), 1'b0, 64'd0, 1'b1, 1'b0);
      cyc(1'b0, 8'd0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 8'd0, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      cyc(1'b0, 8'd0, 1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
      idle(); idle();

      // Asynchronous reset mid-operation
      cyc(1'b0, 8'd0, 1'b0, 64'd0, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) cyc(1'b1, 8'($urandom), 1'b0, 64'd0, 1'b1, 1'b0);
      cyc(1'b0, 8'd0, 1'b1, splat(33), 1'b0, 1'b0);
      mask_valid = 1'b0; grad_valid = 1'b0; clear = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("t6_count", {59'd0, count}, 64'd0);
      chk("t6_out_valid", {63'd0, out_valid}, 64'd0);
      chk("t6_out_data", out_data, 64'd0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      cyc(1'b1, 8'hC3, 1'b0, 64'd0, 1'b1, 1'b0);
      cyc(1'b0, 8'd0, 1'b1, splat(-3), 1'b1, 1'b0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
             {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 40) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
